// File: rtl/reg_scoreboard_if.sv
// Issue-pair scoreboard interface.
// Bundles the issue-side request signals (both pipe slots, HI/LO traffic,
// multiply/divide completion, flush) and the scoreboard responses
// (stall, second_hold, busy_mask, hilo_busy).
//   master : issue logic driving requests and consuming responses
//   slave  : the scoreboard itself
interface reg_scoreboard_if #(
  parameter int NREG = 32,
  parameter int LATW = 2
);
  // Main-pipe slot
  logic            first_issue;
  logic            first_dst_en;
  logic [4:0]      first_dst_addr;
  logic [LATW-1:0] first_lat;
  logic [4:0]      first_src_a;
  logic [4:0]      first_src_b;
  logic            first_hilo_wr;
  logic            first_hilo_rd;
  // Auxiliary-pipe slot
  logic            second_issue;
  logic            second_dst_en;
  logic [4:0]      second_dst_addr;
  logic [LATW-1:0] second_lat;
  logic [4:0]      second_src_a;
  logic [4:0]      second_src_b;
  logic            second_hilo_wr;
  logic            second_hilo_rd;
  // Global events
  logic            muldiv_done;
  logic            flush;
  // Responses
  logic            stall;
  logic            second_hold;
  logic [NREG-1:0] busy_mask;
  logic            hilo_busy;

  modport master (
    output first_issue, first_dst_en, first_dst_addr, first_lat,
           first_src_a, first_src_b, first_hilo_wr, first_hilo_rd,
           second_issue, second_dst_en, second_dst_addr, second_lat,
           second_src_a, second_src_b, second_hilo_wr, second_hilo_rd,
           muldiv_done, flush,
    input  stall, second_hold, busy_mask, hilo_busy
  );

  modport slave (
    input  first_issue, first_dst_en, first_dst_addr, first_lat,
           first_src_a, first_src_b, first_hilo_wr, first_hilo_rd,
           second_issue, second_dst_en, second_dst_addr, second_lat,
           second_src_a, second_src_b, second_hilo_wr, second_hilo_rd,
           muldiv_done, flush,
    output stall, second_hold, busy_mask, hilo_busy
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard.
// Tracks, per GPR, how many cycles remain until its pending result becomes
// forwardable, plus a single HI/LO-pending flag for the multiply/divide unit.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   sb  : reg_scoreboard_if.slave -- issue requests in, stall/second_hold,
//         busy_mask and hilo_busy out
// r0 is hard-wired ready: its counter is never loaded.
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int LATW = 2
) (
  input logic              clk,
  input logic              rst,
  reg_scoreboard_if.slave  sb
);

  logic [LATW-1:0] cnt      [NREG];
  logic [LATW-1:0] cnt_next [NREG];
  logic [NREG-1:0] busy;
  logic            hilo_busy_q;
  logic            ld_first;
  logic            ld_second;
  logic            hilo_set;
  logic            stall_c;
  logic            hold_c;

  // A source is not-ready when it names a tracked register with a pending result.
  function automatic logic not_ready(input logic [4:0] a, input logic [NREG-1:0] mask);
    return (a != 5'd0) && (int'(a) < NREG) && mask[a];
  endfunction

  // Intra-pair RAW: the second slot reads what the first slot writes this
  // cycle. A zero-latency (ALU) producer is covered by forwarding.
  function automatic logic pair_dep(input logic [4:0] s);
    return sb.first_dst_en && (sb.first_dst_addr != 5'd0) &&
           (s == sb.first_dst_addr) && (sb.first_lat != '0);
  endfunction

  assign ld_first  = sb.first_issue  && sb.first_dst_en  && (sb.first_dst_addr  != 5'd0);
  assign ld_second = sb.second_issue && sb.second_dst_en && (sb.second_dst_addr != 5'd0);
  assign hilo_set  = (sb.first_issue && sb.first_hilo_wr) || (sb.second_issue && sb.second_hilo_wr);

  // Next counter values: saturating decrement, overridden by a new load.
  // The second slot is applied last so the younger instruction wins.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_next[r] = (cnt[r] != '0) ? cnt[r] - LATW'(1) : '0;
      if (ld_first && (int'(sb.first_dst_addr) == r))
        cnt_next[r] = sb.first_lat;
      if (ld_second && (int'(sb.second_dst_addr) == r))
        cnt_next[r] = sb.second_lat;
    end
  end

  // NOTE: the counter array is reset like ordinary flops (not left to power-up
  // garbage) because stale nonzero entries would stall issue after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      hilo_busy_q <= 1'b0;
    end else if (sb.flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      hilo_busy_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_next[r];
      // Set beats clear: a new mult/div issued alongside completion keeps HI/LO busy.
      if (hilo_set)
        hilo_busy_q <= 1'b1;
      else if (sb.muldiv_done)
        hilo_busy_q <= 1'b0;
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) busy[r] = (cnt[r] != '0);
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    stall_c = 1'b0;
    hold_c  = 1'b0;
    if (not_ready(sb.first_src_a, busy) || not_ready(sb.first_src_b, busy) ||
        (sb.first_hilo_rd && hilo_busy_q))
      stall_c = 1'b1;
    if (not_ready(sb.second_src_a, busy) || not_ready(sb.second_src_b, busy) ||
        pair_dep(sb.second_src_a) || pair_dep(sb.second_src_b) ||
        (sb.second_hilo_rd && (hilo_busy_q || sb.first_hilo_wr)))
      hold_c = 1'b1;
    // Holding the whole pair already covers the second slot.
    if (stall_c)
      hold_c = 1'b0;
  end

  assign sb.stall       = stall_c;
  assign sb.second_hold = hold_c;
  assign sb.busy_mask   = busy;
  assign sb.hilo_busy   = hilo_busy_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard.
// A behavioural model records, per register, the edge number at which its
// result becomes ready; a compare process checks every output against it at
// each falling edge, and directed scenarios add hand-computed literal checks.
module tb_reg_scoreboard;
  localparam int NREG = 32;
  localparam int LATW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.NREG(NREG), .LATW(LATW)) sb ();

  reg_scoreboard #(.NREG(NREG), .LATW(LATW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int edge_n = 0;
  int ready_at [NREG];
  bit m_hilo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      m_hilo = 0;
    end else begin
      edge_n++;
      if (sb.flush) begin
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        m_hilo = 0;
      end else begin
        if (sb.first_issue && sb.first_dst_en && sb.first_dst_addr != 0)
          ready_at[sb.first_dst_addr] = edge_n + int'(sb.first_lat);
        if (sb.second_issue && sb.second_dst_en && sb.second_dst_addr != 0)
          ready_at[sb.second_dst_addr] = edge_n + int'(sb.second_lat);
        if ((sb.first_issue && sb.first_hilo_wr) || (sb.second_issue && sb.second_hilo_wr))
          m_hilo = 1;
        else if (sb.muldiv_done)
          m_hilo = 0;
      end
    end
  end

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 0) && (edge_n < ready_at[r]);
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int r = 1; r < NREG; r++) m[r] = (edge_n < ready_at[r]);
    return m;
  endfunction

  function automatic bit m_stall();
    return m_busy(sb.first_src_a) || m_busy(sb.first_src_b) || (sb.first_hilo_rd && m_hilo);
  endfunction

  function automatic bit m_dep(input logic [4:0] s);
    return sb.first_dst_en && sb.first_dst_addr != 0 && s == sb.first_dst_addr && sb.first_lat != 0;
  endfunction

  function automatic bit m_hold();
    if (m_stall()) return 0;
    return m_busy(sb.second_src_a) || m_busy(sb.second_src_b) ||
           m_dep(sb.second_src_a) || m_dep(sb.second_src_b) ||
           (sb.second_hilo_rd && (m_hilo || sb.first_hilo_wr));
  endfunction

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("model_busy_mask", sb.busy_mask, m_mask());
      check("model_hilo_busy", 32'(sb.hilo_busy), 32'(m_hilo));
      check("model_stall", 32'(sb.stall), 32'(m_stall()));
      check("model_second_hold", 32'(sb.second_hold), 32'(m_hold()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    sb.first_issue = 0; sb.first_dst_en = 0; sb.first_dst_addr = 0; sb.first_lat = 0;
    sb.first_src_a = 0; sb.first_src_b = 0; sb.first_hilo_wr = 0; sb.first_hilo_rd = 0;
    sb.second_issue = 0; sb.second_dst_en = 0; sb.second_dst_addr = 0; sb.second_lat = 0;
    sb.second_src_a = 0; sb.second_src_b = 0; sb.second_hilo_wr = 0; sb.second_hilo_rd = 0;
    sb.muldiv_done = 0; sb.flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic first_wr(input logic [4:0] a, input logic [1:0] lat);
    sb.first_issue = 1; sb.first_dst_en = 1; sb.first_dst_addr = a; sb.first_lat = lat;
  endtask

  task automatic second_wr(input logic [4:0] a, input logic [1:0] lat);
    sb.second_issue = 1; sb.second_dst_en = 1; sb.second_dst_addr = a; sb.second_lat = lat;
  endtask

  initial begin
    idle();
    #3;
    check("reset_busy_mask", sb.busy_mask, 32'h0);
    check("reset_hilo_busy", 32'(sb.hilo_busy), 32'h0);
    check("reset_stall", 32'(sb.stall), 32'h0);
    check("reset_second_hold", 32'(sb.second_hold), 32'h0);
    #14 rst = 1'b0;   // released at t=17, away from any edge

    // lw $5 (lat 1) then dependent reader
    tick();
    first_wr(5, 1);
    #1 check("lw5_before_edge", sb.busy_mask, 32'h0);
    tick();
    idle(); sb.first_src_a = 5;
    #1 check("lw5_busy", sb.busy_mask, 32'h0000_0020);
    check("lw5_stall", 32'(sb.stall), 32'h1);
    tick();
    #1 check("lw5_ready_stall", 32'(sb.stall), 32'h0);
    check("lw5_ready_mask", sb.busy_mask, 32'h0);

    // Intra-pair dependency: ALU producer forwards, load producer holds
    idle();
    first_wr(3, 0); sb.second_issue = 1; sb.second_src_b = 3;
    #1 check("pair_alu_hold", 32'(sb.second_hold), 32'h0);
    sb.first_lat = 1;
    #1 check("pair_load_hold", 32'(sb.second_hold), 32'h1);
    check("pair_load_stall", 32'(sb.stall), 32'h0);
    sb.first_dst_en = 0;
    #1 check("pair_no_dst_hold", 32'(sb.second_hold), 32'h0);
    idle();

    // Both slots write $7: younger (lat 1) wins
    tick();
    first_wr(7, 3); second_wr(7, 1);
    tick();
    idle();
    #1 check("waw7_busy", sb.busy_mask, 32'h0000_0080);
    tick();
    #1 check("waw7_ready", sb.busy_mask, 32'h0);

    // Auxiliary slot source not ready
    second_wr(10, 2);
    tick();
    idle(); sb.second_src_a = 10;
    #1 check("aux_src_hold", 32'(sb.second_hold), 32'h1);
    check("aux_src_stall", 32'(sb.stall), 32'h0);
    tick(); tick();
    idle();

    // mult then mflo; done coinciding with a new mult keeps HI/LO busy
    sb.first_issue = 1; sb.first_hilo_wr = 1;
    tick();
    idle(); sb.first_hilo_rd = 1; sb.second_hilo_rd = 1;
    #1 check("mflo_stall", 32'(sb.stall), 32'h1);
    check("mflo_hold_masked", 32'(sb.second_hold), 32'h0);
    tick();
    #1 check("mflo_stall_2", 32'(sb.stall), 32'h1);
    idle(); sb.muldiv_done = 1; sb.second_issue = 1; sb.second_hilo_wr = 1;
    tick();
    idle();
    #1 check("hilo_set_priority", 32'(sb.hilo_busy), 32'h1);
    sb.muldiv_done = 1;
    tick();
    idle(); sb.first_hilo_rd = 1;
    #1 check("hilo_cleared", 32'(sb.hilo_busy), 32'h0);
    check("mflo_go", 32'(sb.stall), 32'h0);
    idle(); sb.first_hilo_wr = 1; sb.second_hilo_rd = 1;
    #1 check("pair_hilo_hold", 32'(sb.second_hold), 32'h1);
    idle();

    // lat 3 on $9 then flush (issue in flush cycle is ignored)
    first_wr(9, 3);
    tick();
    idle(); sb.flush = 1; sb.first_src_a = 9; second_wr(4, 2);
    #1 check("flush_pre_stall", 32'(sb.stall), 32'h1);
    tick();
    idle(); sb.first_src_a = 9;
    #1 check("flush_mask", sb.busy_mask, 32'h0);
    check("flush_stall", 32'(sb.stall), 32'h0);
    idle();

    // Write to $0 never tracked
    first_wr(0, 3);
    tick();
    idle(); sb.first_src_a = 0; sb.second_issue = 1; sb.second_src_a = 0;
    #1 check("r0_mask", sb.busy_mask, 32'h0);
    check("r0_stall", 32'(sb.stall), 32'h0);
    check("r0_hold", 32'(sb.second_hold), 32'h0);
    tick();
    idle();

    // Reset mid-countdown
    first_wr(12, 3); sb.second_issue = 1; sb.second_hilo_wr = 1;
    tick();
    idle(); sb.first_src_a = 12; sb.first_hilo_rd = 1;
    #1 check("pre_rst_mask", sb.busy_mask, 32'h0000_1000);
    check("pre_rst_hilo", 32'(sb.hilo_busy), 32'h1);
    #1 rst = 1'b1;
    #1 check("rst_async_mask", sb.busy_mask, 32'h0);
    check("rst_async_hilo", 32'(sb.hilo_busy), 32'h0);
    check("rst_async_stall", 32'(sb.stall), 32'h0);
    check("rst_async_hold", 32'(sb.second_hold), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick(); tick();
    check("post_rst_stall", 32'(sb.stall), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is short; never let the run hang.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have the parameter NREG, default 32, meaning the number of architectural GPRs tracked; r0 is never tracked.
REQ-002 SHALL have the parameter LATW, default 2, meaning the width of each per-register countdown counter.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have the port: clk  input  1  rising-edge clock.
REQ-005 SHALL have the port: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have the port: first_issue  input  1  main-pipe instruction leaves the issue stage this cycle.
REQ-007 SHALL have the port: first_dst_en  input  1  main-pipe instruction writes a GPR.
REQ-008 SHALL have the port: first_dst_addr  input  5  main-pipe destination register.
REQ-009 SHALL have the port: first_lat  input  LATW  cycles until the main-pipe result is forwardable (0 = ALU, 1 = load, 2..3 = long ops).
REQ-010 SHALL have the port: first_src_a, first_src_b  input  5 each  main-pipe source registers.
REQ-011 SHALL have the port: second_issue, second_dst_en, second_dst_addr, second_lat, second_src_a, second_src_b  input  same widths  auxiliary-pipe equivalents.
REQ-012 SHALL have the port: first_hilo_wr, second_hilo_wr  input  1 each  issuing instruction is mult/div.
REQ-013 SHALL have the port: first_hilo_rd, second_hilo_rd  input  1 each  instruction at issue reads HI/LO.
REQ-014 SHALL have the port: muldiv_done  input  1  multiply/divide unit result written.
REQ-015 SHALL have the port: flush  input  1  exception/branch-miss flush.
REQ-016 SHALL have the port: stall  output  1  hold the entire issue pair.
REQ-017 SHALL have the port: second_hold  output  1  issue the main-pipe slot only.
REQ-018 SHALL have the port: busy_mask  output  NREG  per-register not-ready bits.
REQ-019 SHALL have the port: hilo_busy  output  1  HI/LO result pending.

Function
REQ-020 SHALL hold one LATW-bit counter cnt[r] per register; register r is not-ready iff cnt[r] != 0, and busy_mask[r] = (cnt[r] != 0).
REQ-021 SHALL decrement every nonzero counter by 1 each cycle and saturate it at 0.
REQ-022 SHALL, on a clock edge with first_issue & first_dst_en & first_dst_addr != 0, load cnt[first_dst_addr] <= first_lat, overriding any decrement of that counter in the same cycle.
REQ-023 SHALL load cnt[second_dst_addr] <= second_lat under the same rule for the auxiliary slot.
REQ-024 SHALL, when both slots load the same address in one cycle, use the second slot's value (the younger instruction wins).
REQ-025 SHALL never make cnt[0] nonzero, so busy_mask[0] is always 0.
REQ-026 SHALL drive stall combinationally as 1 when any nonzero first_src_a/first_src_b is not-ready, or when first_hilo_rd & hilo_busy.
REQ-027 SHALL drive second_hold combinationally as 1, while stall = 0, when any of the following holds: a nonzero second source is not-ready; a second source equals first_dst_addr with first_dst_en, a nonzero address and first_lat != 0; second_hilo_rd and (hilo_busy or first_hilo_wr).
REQ-028 SHALL force second_hold to 0 whenever stall = 1.
REQ-029 SHALL treat an intra-pair dependency with first_lat = 0 as no hold, because the result is resolved by forwarding.
REQ-030 SHALL set hilo_busy on a clock edge with (first_issue & first_hilo_wr) | (second_issue & second_hilo_wr).
REQ-031 SHALL clear hilo_busy on a clock edge with muldiv_done.
REQ-032 SHALL give set priority when set and clear of hilo_busy occur in the same cycle.
REQ-033 SHALL, on a clock edge with flush = 1, clear all counters and hilo_busy, ignoring issue inputs in that cycle.
REQ-034 SHALL make busy_mask and hilo_busy registered state with zero extra latency: a load with lat = 1 issued at edge N is busy during cycle N..N+1 and ready from edge N+1 onward.

Reset
REQ-035 SHALL, while rst = 1, asynchronously clear all cnt[r] and hilo_busy, giving busy_mask = 0 and hilo_busy = 0.
REQ-036 SHALL make stall and second_hold depend only on the current inputs after reset, both 0 with idle inputs.
REQ-037 SHALL let reset asserted mid-countdown discard every pending entry immediately.

Verification
REQ-038 SHALL cover: issue first lw $5 (lat = 1) -> busy_mask[5] = 1 for one cycle; next-cycle first_src_a = 5 -> stall = 1; cycle after that -> stall = 0.
REQ-039 SHALL cover: pair first addu $3 (lat 0), second_src_b = 3 -> second_hold = 0; with first_lat = 1 -> second_hold = 1, stall = 0.
REQ-040 SHALL cover: both slots write $7 in one cycle, lat 3 and 1 -> cnt[7] = 1, and $7 is ready after one cycle.
REQ-041 SHALL cover: mult issued, then mflo at issue -> stall = 1 until muldiv_done; muldiv_done coinciding with a new mult issue -> hilo_busy stays 1.
REQ-042 SHALL cover: lat 3 on $9, then flush next cycle -> busy_mask = 0 and the dependent reader gets stall = 0.
REQ-043 SHALL cover: write to $0 with lat 3 -> busy_mask = 0, and a reader of $0 never stalls; rst asserted mid-countdown -> all outputs 0 asynchronously.
